branch_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one output channel between NREQ requesters (the
//  a/b/c branch sources). Each requester presents a word under valid/ready.
//  One winner per cycle is captured into a single-entry output register.

---
 rtl/branch_rr_arbiter_if.sv | 59 +++++
 rtl/branch_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_branch_rr_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/branch_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// branch_rr_arbiter_if
//   Bundles the requester side (valid/data/ready per source) and the output
//   side (held word, its source index, downstream ready) of the round-robin
//   arbiter that feeds the shared assign/output stage of module m.
//
// Parameters
//   NREQ  number of requesters (>= 2)
//   DW    data width per requester
//   SW    width of the source index, derived from NREQ
//
// Signals
//   req_valid  [NREQ]     per-requester word valid
//   req_data   [NREQ*DW]  requester i data at [i*DW +: DW]
//   req_ready  [NREQ]     one-hot (or zero) accept strobe from the arbiter
//   out_valid             output register holds a word
//   out_data   [DW]       held word
//   out_src    [SW]       index of the requester that supplied out_data
//   out_ready             downstream accepts when out_valid & out_ready
//
// Modports
//   master  environment side: drives requests and out_ready
//   slave   arbiter side: drives req_ready and the output register
// ---------------------------------------------------------------------------
interface branch_rr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8
);
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_src;
  logic               out_ready;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/branch_rr_arbiter.sv
// ---------------------------------------------------------------------------
// branch_rr_arbiter
//   Round-robin arbiter sharing one output channel between NREQ requesters
//   (the a/b/c branch sources). One winner per cycle is captured into a
//   single-entry output register. A drain and a load may happen on the same
//   edge, so a continuously fed channel moves one word per cycle.
//
// Ports
//   clk   in  clock, all state on the rising edge
//   rst   in  synchronous reset, active-high; discards any held word
//   bus   slave modport of branch_rr_arbiter_if (see interface header)
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_EMPTY | output register empty, out_valid=0, any winner may load
//   ST_FULL  | output register holds a word, out_valid=1; a new winner
//            | loads only when the held word drains on the same edge
// ---------------------------------------------------------------------------
module branch_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 8
) (
  input  logic                clk,
  input  logic                rst,
  branch_rr_arbiter_if.slave  bus
);

  localparam int SW = $clog2(NREQ);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_q;
  logic [SW-1:0]   ptr_q;
  logic [DW-1:0]   data_q;
  logic [SW-1:0]   src_q;

  logic            found;
  logic [SW-1:0]   win;
  logic [DW-1:0]   win_data;
  logic [SW-1:0]   ptr_next;
  logic            load_ok;
  logic            transfer;
  logic [NREQ-1:0] grant;

  // Scan from ptr upward, wrapping modulo NREQ. ptr is always < NREQ, so a
  // single conditional subtract keeps the candidate index in range.
  always_comb begin : scan
    int            idx;
    logic [SW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = SW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin : data_mux
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (SW'(k) == win) win_data = bus.req_data[k*DW +: DW];
    end
  end

  // The register can take a word when empty, or when the held word leaves
  // on this same edge. Grants are suppressed while reset is asserted.
  assign load_ok  = (state_q == ST_EMPTY) | bus.out_ready;
  assign transfer = found & load_ok & ~rst;
  assign ptr_next = (win == SW'(NREQ - 1)) ? '0 : win + SW'(1);

  always_comb begin
    grant = '0;
    if (transfer) grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (transfer) begin
            state_q <= ST_FULL;
            data_q  <= win_data;
            src_q   <= win;
            ptr_q   <= ptr_next;
          end
        end
        ST_FULL: begin
          if (transfer) begin
            // drain and reload together: new word replaces the old one
            data_q <= win_data;
            src_q  <= win;
            ptr_q  <= ptr_next;
          end else if (bus.out_ready) begin
            // out_data/out_src intentionally keep their last value
            state_q <= ST_EMPTY;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_branch_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_branch_rr_arbiter
//   Directed bench for branch_rr_arbiter with NREQ=3, DW=8. Inputs change
//   1 time unit after a rising edge; req_ready is checked once inputs have
//   settled, registered outputs 1 unit after the following edge.
// ---------------------------------------------------------------------------
module tb_branch_rr_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 8;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  branch_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  branch_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [7:0] d, input logic [1:0] s);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".data"},  32'(bus.out_data),  32'(d));
    check({tag, ".src"},   32'(bus.out_src),   32'(s));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // 1: reset held 3 cycles with every requester valid
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_data  = {8'h12, 8'h11, 8'h10};
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    check("rst.req_ready", 32'(bus.req_ready), 32'h0);
    check_out("rst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    #1;
    check("rel.req_ready", 32'(bus.req_ready), 32'b001);
    step();
    check_out("rel.first", 1'b1, 8'h10, 2'd0);        // ptr -> 1
    bus.req_valid = 3'b000;
    #1;
    check("idle.req_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_out("drain.keep", 1'b0, 8'h10, 2'd0);       // data held, ptr 1

    // 2: only requester 1 valid
    bus.req_data  = {8'h12, 8'h5A, 8'h10};
    bus.req_valid = 3'b010;
    #1;
    check("single.req_ready", 32'(bus.req_ready), 32'b010);
    step();
    check_out("single", 1'b1, 8'h5A, 2'd1);           // ptr -> 2
    bus.req_valid = 3'b000;
    step();
    check("single.drain", 32'(bus.out_valid), 32'h0);

    // 5: wrap with ptr=2, requesters 0 and 2 valid -> 2, 0, 2
    bus.req_data  = {8'h12, 8'h11, 8'h10};
    bus.req_valid = 3'b101;
    #1;
    check("wrap0.req_ready", 32'(bus.req_ready), 32'b100);
    step();
    check_out("wrap0", 1'b1, 8'h12, 2'd2);            // ptr -> 0
    check("wrap1.req_ready", 32'(bus.req_ready), 32'b001);
    step();
    check_out("wrap1", 1'b1, 8'h10, 2'd0);            // ptr -> 1
    check("wrap2.req_ready", 32'(bus.req_ready), 32'b100);
    step();
    check_out("wrap2", 1'b1, 8'h12, 2'd2);            // ptr -> 0

    // 3: all valid, out_ready=1 -> 0,1,2,0,1,2 back to back
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] s;
      s = 2'(i % 3);
      #1;
      check("rr.req_ready", 32'(bus.req_ready), 32'(3'b001 << s));
      step();
      check_out("rr", 1'b1, 8'h10 + 8'(s), s);
    end
    // now FULL with word from req 2, ptr = 0

    // 4: backpressure for 5 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.req_ready", 32'(bus.req_ready), 32'h0);
      step();
      check_out("bp.hold", 1'b1, 8'h12, 2'd2);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release.req_ready", 32'(bus.req_ready), 32'b001);
    step();
    check_out("bp.reload", 1'b1, 8'h10, 2'd0);        // ptr -> 1

    // 6: reset while FULL, downstream not ready
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #1;
    check("rst6.req_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_out("rst6", 1'b0, 8'h00, 2'd0);
    rst           = 1'b0;
    bus.req_valid = 3'b000;
    bus.out_ready = 1'b1;
    step();
    check("rst6.no_redeliver", 32'(bus.out_valid), 32'h0);
    bus.req_valid = 3'b111;
    #1;
    check("rst6.ptr0", 32'(bus.req_ready), 32'b001);
    step();
    check_out("rst6.grant", 1'b1, 8'h10, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
